// File: rtl/render_cmd_pkg.sv
// Shared types for the renderer command master: register map, queued command
// layout and the issue FSM state encoding.
package render_cmd_pkg;

   localparam logic [3:0] REG_X    = 4'd1;
   localparam logic [3:0] REG_Y    = 4'd2;
   localparam logic [3:0] REG_CODE = 4'd4;
   localparam logic [3:0] REG_GO   = 4'd6;

   // kind 0 = positioned sprite, kind 1 = unpositioned fill/line
   typedef struct packed {
      logic       kind;
      logic [7:0] code;
      logic [8:0] x;
      logic [7:0] y;
   } cmd_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_CODE,
      ST_WR_X,
      ST_WR_Y,
      ST_WR_GO
   } state_e;

endpackage

// File: rtl/render_cmd_fifo.sv
// Show-ahead command queue; the head entry is visible on rdata_o whenever
// empty_o is low. Pushes into a full queue are dropped even if a pop coincides.
module render_cmd_fifo
   import render_cmd_pkg::*;
#(
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  cmd_t          wdata_i,
   input  logic          pop_i,
   output cmd_t          rdata_o,
   output logic [AW:0]   count_o,
   output logic          full_o,
   output logic          empty_o
);

   localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

   cmd_t          mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign full_o  = (count_q == DEPTH_CNT);
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/render_cmd_master.sv
// Avalon-MM write master draining queued draw commands into the renderer
// register file: code, then x/y for sprites, then plot-go.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | no command in flight, waiting for the queue
// WR_CODE  | writing texture/colour code to REG_CODE
// WR_X     | writing midpoint x to REG_X (sprites only)
// WR_Y     | writing midpoint y to REG_Y (sprites only)
// WR_GO    | writing plot-go to REG_GO; may stall for a whole plot
module render_cmd_master
   import render_cmd_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_kind,
   input  logic [7:0]    cmd_code,
   input  logic [8:0]    cmd_x,
   input  logic [7:0]    cmd_y,
   output logic [3:0]    master_address,
   output logic          master_write,
   output logic [31:0]   master_writedata,
   input  logic          master_waitrequest,
   output logic          busy,
   output logic [CW-1:0] cmd_count
);

   state_e state_q, state_d;
   cmd_t   cur_q, cur_d;
   cmd_t   head, push_data;
   logic   pop, fifo_full, fifo_empty;

   assign push_data = '{kind: cmd_kind, code: cmd_code, x: cmd_x, y: cmd_y};

   render_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (cmd_valid),
      .wdata_i (push_data),
      .pop_i   (pop),
      .rdata_o (head),
      .count_o (cmd_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign cmd_ready = ~fifo_full;
   assign busy      = (state_q != ST_IDLE) | (cmd_count != '0);

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      pop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               cur_d   = head;
               state_d = ST_WR_CODE;
            end
         end
         ST_WR_CODE: if (!master_waitrequest) state_d = cur_q.kind ? ST_WR_GO : ST_WR_X;
         ST_WR_X:    if (!master_waitrequest) state_d = ST_WR_Y;
         ST_WR_Y:    if (!master_waitrequest) state_d = ST_WR_GO;
         ST_WR_GO: begin
            // Chain straight into the next command so the bus sees no idle cycle.
            if (!master_waitrequest) begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  cur_d   = head;
                  state_d = ST_WR_CODE;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      master_write     = 1'b1;
      master_address   = 4'd0;
      master_writedata = 32'd0;
      case (state_q)
         ST_WR_CODE: begin
            master_address   = REG_CODE;
            master_writedata = {24'b0, cur_q.code};
         end
         ST_WR_X: begin
            master_address   = REG_X;
            master_writedata = {23'b0, cur_q.x};
         end
         ST_WR_Y: begin
            master_address   = REG_Y;
            master_writedata = {24'b0, cur_q.y};
         end
         ST_WR_GO: master_address = REG_GO;
         default:  master_write   = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cur_q   <= '0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
      end
   end

endmodule

// File: tb/tb_render_cmd_master.sv
// Directed bench for render_cmd_master: inputs change and outputs are sampled
// on the falling clock edge, away from the active rising edge.
module tb_render_cmd_master;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_kind;
   logic [7:0]  cmd_code;
   logic [8:0]  cmd_x;
   logic [7:0]  cmd_y;
   logic [3:0]  master_address;
   logic        master_write;
   logic [31:0] master_writedata;
   logic        master_waitrequest;
   logic        busy;
   logic [3:0]  cmd_count;

   int total = 0;
   int bad   = 0;
   int accepted;

   logic [3:0]  stall_addr [4]  = '{4'd4, 4'd1, 4'd2, 4'd6};
   logic [31:0] stall_data [4]  = '{32'd1, 32'd20, 32'd20, 32'd0};
   logic [3:0]  bb_addr    [10] = '{4'd4, 4'd1, 4'd2, 4'd6, 4'd4, 4'd6, 4'd4, 4'd1, 4'd2, 4'd6};
   logic [31:0] bb_data    [10] = '{32'h06, 32'd159, 32'd119, 32'd0, 32'h1F, 32'd0,
                                    32'h09, 32'd307, 32'd119, 32'd0};

   render_cmd_master #(.FIFO_DEPTH(8)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .cmd_valid          (cmd_valid),
      .cmd_ready          (cmd_ready),
      .cmd_kind           (cmd_kind),
      .cmd_code           (cmd_code),
      .cmd_x              (cmd_x),
      .cmd_y              (cmd_y),
      .master_address     (master_address),
      .master_write       (master_write),
      .master_writedata   (master_writedata),
      .master_waitrequest (master_waitrequest),
      .busy               (busy),
      .cmd_count          (cmd_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_wr(input string tag, input logic [3:0] a, input logic [31:0] d);
      check({tag, "_write"}, 32'(master_write), 32'd1);
      check({tag, "_addr"},  32'(master_address), 32'(a));
      check({tag, "_data"},  master_writedata, d);
   endtask

   task automatic drive(input logic k, input logic [7:0] c, input logic [8:0] x, input logic [7:0] y);
      cmd_valid = 1'b1;
      cmd_kind  = k;
      cmd_code  = c;
      cmd_x     = x;
      cmd_y     = y;
   endtask

   initial begin
      rst_n = 1'b0;
      cmd_valid = 1'b0;
      cmd_kind = 1'b0;
      cmd_code = '0;
      cmd_x = '0;
      cmd_y = '0;
      master_waitrequest = 1'b0;

      // reset values
      repeat (2) @(negedge clk);
      check("rst_write", 32'(master_write), 32'd0);
      check("rst_addr",  32'(master_address), 32'd0);
      check("rst_data",  master_writedata, 32'd0);
      check("rst_ready", 32'(cmd_ready), 32'd1);
      check("rst_busy",  32'(busy), 32'd0);
      check("rst_count", 32'(cmd_count), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // kind-1 fill, no stalls
      drive(1'b1, 8'hFC, 9'd0, 8'd0);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("fill_lat_write", 32'(master_write), 32'd0);
      check("fill_lat_count", 32'(cmd_count), 32'd1);
      check("fill_lat_busy",  32'(busy), 32'd1);
      @(negedge clk);
      expect_wr("fill_code", 4'd4, 32'hFC);
      @(negedge clk);
      expect_wr("fill_go", 4'd6, 32'd0);
      @(negedge clk);
      check("fill_end_write", 32'(master_write), 32'd0);
      check("fill_end_busy",  32'(busy), 32'd0);

      // sprite with 3 stall cycles per phase
      drive(1'b0, 8'h01, 9'd20, 8'd20);
      master_waitrequest = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int p = 0; p < 4; p++) begin
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            expect_wr($sformatf("stall_p%0d_c%0d", p, k), stall_addr[p], stall_data[p]);
            master_waitrequest = (k != 3);
         end
      end
      @(negedge clk);
      check("stall_end_write", 32'(master_write), 32'd0);
      check("stall_end_busy",  32'(busy), 32'd0);

      // back-to-back commands, no gaps, x passed unclipped
      master_waitrequest = 1'b0;
      drive(1'b0, 8'h06, 9'd159, 8'd119);
      @(negedge clk);
      drive(1'b1, 8'h1F, 9'd0, 8'd0);
      @(negedge clk);
      drive(1'b0, 8'h09, 9'd307, 8'd119);
      expect_wr("bb_0", bb_addr[0], bb_data[0]);
      @(negedge clk);
      cmd_valid = 1'b0;
      expect_wr("bb_1", bb_addr[1], bb_data[1]);
      for (int i = 2; i < 10; i++) begin
         @(negedge clk);
         expect_wr($sformatf("bb_%0d", i), bb_addr[i], bb_data[i]);
      end
      @(negedge clk);
      check("bb_end_write", 32'(master_write), 32'd0);
      check("bb_end_busy",  32'(busy), 32'd0);

      // full queue under permanent stall
      master_waitrequest = 1'b1;
      accepted = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         drive(1'b0, 8'(i), 9'(i), 8'(i));
         if (cmd_ready) accepted++;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      check("full_accepted", 32'(accepted), 32'd9);
      check("full_ready",    32'(cmd_ready), 32'd0);
      check("full_count",    32'(cmd_count), 32'd8);
      check("full_busy",     32'(busy), 32'd1);
      expect_wr("full_head", 4'd4, 32'd0);

      // reset flushes a full queue
      rst_n = 1'b0;
      #1;
      check("flush_write", 32'(master_write), 32'd0);
      check("flush_count", 32'(cmd_count), 32'd0);
      check("flush_ready", 32'(cmd_ready), 32'd1);
      check("flush_busy",  32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      master_waitrequest = 1'b0;

      // reset while stalled in WR_Y with 3 queued
      @(negedge clk);
      drive(1'b0, 8'h11, 9'd100, 8'd50);
      @(negedge clk);
      drive(1'b0, 8'h22, 9'd101, 8'd51);
      @(negedge clk);
      drive(1'b0, 8'h33, 9'd102, 8'd52);
      @(negedge clk);
      drive(1'b0, 8'h44, 9'd103, 8'd53);
      @(negedge clk);
      cmd_valid = 1'b0;
      master_waitrequest = 1'b1;
      expect_wr("mid_y", 4'd2, 32'd50);
      check("mid_count", 32'(cmd_count), 32'd3);
      @(negedge clk);
      expect_wr("mid_y_held", 4'd2, 32'd50);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_write", 32'(master_write), 32'd0);
      check("mid_rst_addr",  32'(master_address), 32'd0);
      check("mid_rst_count", 32'(cmd_count), 32'd0);
      check("mid_rst_busy",  32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      master_waitrequest = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("post_rst_write_%0d", i), 32'(master_write), 32'd0);
      end
      check("post_rst_count", 32'(cmd_count), 32'd0);
      check("post_rst_busy",  32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
